// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the writeback request bus and the register file write port.
//   master : writeback sources (drive requests, see grants/stall/write port)
//   slave  : the arbiter
//   req_valid_i/req_addr_i/req_data_i : per-requester request, k at [5k+:5]/[32k+:32]
//   req_ready_o : one-hot-or-zero grant, stall_o : pipeline stall
//   RegWrite_o/RDaddr_o/RDdata_o : registered register file write port
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [5*NUM_REQ-1:0]  req_addr_i;
    logic [32*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic                  stall_o;
    logic                  RegWrite_o;
    logic [4:0]            RDaddr_o;
    logic [31:0]           RDdata_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i,
        input  req_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i,
        output req_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register file write port among NUM_REQ writeback
//   sources. Requester 0 (pipeline WB) wins over the multi-cycle units
//   unless one of them has been blocked MAX_WAIT cycles; the multi-cycle
//   units share round-robin. The write port is registered (1-cycle latency).
//   Ports: clk_i, rst_i (sync, active-high), bus (regfile_wb_arbiter_if.slave).

// Per-requester blocked-cycle counter (4-bit, saturating).
module regfile_wb_arbiter_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid,
    input  logic granted,
    output logic starving
);
    logic [3:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)                 cnt <= '0;
        else if (!valid || granted) cnt <= '0;
        else if (cnt != 4'hF)      cnt <= cnt + 4'd1;
    end

    assign starving = valid && (cnt >= 4'(MAX_WAIT));
endmodule

module regfile_wb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_WAIT = 4,
    parameter bit DROP_R0  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW     = $clog2(NUM_REQ);
    localparam int STAGES = 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    wr_req_t [NUM_REQ-1:0] req;
    logic    [NUM_REQ-1:0] valid;
    logic    [NUM_REQ-1:0] starving;
    logic    [NUM_REQ-1:0] gnt;
    logic    [PW-1:0]      gnt_idx;
    logic                  gnt_vld;
    logic    [PW-1:0]      rr_ptr;
    logic    [STAGES:0]    vld_pipe;
    logic    [4:0]         wr_addr;
    logic    [31:0]        wr_data;

    assign valid = bus.req_valid_i;

    // Requester 0 never starves; it already has priority.
    assign starving[0] = 1'b0;

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_req
            assign req[k].addr = bus.req_addr_i[5*k +: 5];
            assign req[k].data = bus.req_data_i[32*k +: 32];
        end
        for (k = 1; k < NUM_REQ; k++) begin : g_wait
            regfile_wb_arbiter_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .valid    (valid[k]),
                .granted  (gnt[k]),
                .starving (starving[k])
            );
        end
    endgenerate

    // Both the starvation scan and the round-robin scan walk requesters
    // 1..NUM_REQ-1 starting at rr_ptr, so they share one loop.
    always_comb begin
        logic          starve_hit, rr_hit;
        logic [PW-1:0] starve_sel, rr_sel;
        starve_hit = 1'b0;
        rr_hit     = 1'b0;
        starve_sel = '0;
        rr_sel     = '0;
        gnt        = '0;
        gnt_idx    = '0;
        gnt_vld    = 1'b0;
        for (int i = 0; i < NUM_REQ-1; i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx > NUM_REQ-1) idx = idx - (NUM_REQ-1);
            if (!starve_hit && starving[idx]) begin
                starve_hit = 1'b1;
                starve_sel = idx[PW-1:0];
            end
            if (!rr_hit && valid[idx]) begin
                rr_hit = 1'b1;
                rr_sel = idx[PW-1:0];
            end
        end
        if (!rst_i) begin
            if (starve_hit) begin
                gnt_vld = 1'b1;
                gnt_idx = starve_sel;
            end else if (valid[0]) begin
                gnt_vld = 1'b1;
                gnt_idx = '0;
            end else if (rr_hit) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_sel;
            end
        end
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end

    assign bus.req_ready_o = gnt;
    assign bus.stall_o     = valid[0] && !gnt[0] && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_ptr <= PW'(1);
        else if (gnt_vld && gnt_idx != '0)
            rr_ptr <= (gnt_idx == PW'(NUM_REQ-1)) ? PW'(1) : gnt_idx + PW'(1);
    end

    // Writes to r0 are accepted but suppressed at the write enable.
    assign vld_pipe[0] = gnt_vld && !(DROP_R0 && req[gnt_idx].addr == 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe[STAGES:1] <= '0;
            wr_addr            <= '0;
            wr_data            <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (gnt_vld) begin
                wr_addr <= req[gnt_idx].addr;
                wr_data <= req[gnt_idx].data;
            end
        end
    end

    assign bus.RegWrite_o = vld_pipe[STAGES];
    assign bus.RDaddr_o   = wr_addr;
    assign bus.RDdata_o   = wr_data;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed scenarios followed by randomized traffic, checked against a
//   cycle-level reference model of the arbitration rules.
module tb_regfile_wb_arbiter;
    localparam int N        = 3;
    localparam int MAX_WAIT = 4;
    localparam bit DROP_R0  = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(N), .MAX_WAIT(MAX_WAIT), .DROP_R0(DROP_R0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_ptr = 1;
    int          m_wt[N];
    logic        m_ow = 1'b0;
    logic [4:0]  m_oa = '0;
    logic [31:0] m_od = '0;
    bit          m_init = 1'b0;
    bit          m_after_rst = 1'b0;
    int          last_g = -1;

    // stimulus held between steps
    logic [N-1:0]         tv = '0;
    logic [N-1:0][4:0]    ta = '0;
    logic [N-1:0][31:0]   td = '0;

    // DUT values sampled in the most recent step
    logic [N-1:0] s_rdy;
    logic         s_stall, s_we;
    logic [4:0]   s_addr;
    logic [31:0]  s_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive tv/ta/td and reset, check against the model, advance.
    task automatic step(input logic r);
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst             = r;
        bus.req_valid_i = tv;
        bus.req_addr_i  = ta;
        bus.req_data_i  = td;
        #1;
        g = -1;
        if (!r) begin
            for (int i = 0; i < N-1; i++) begin
                int kk;
                kk = 1 + ((m_ptr - 1 + i) % (N-1));
                if (g < 0 && tv[kk] && m_wt[kk] >= MAX_WAIT) g = kk;
            end
            if (g < 0 && tv[0]) g = 0;
            for (int i = 0; i < N-1; i++) begin
                int kk;
                kk = 1 + ((m_ptr - 1 + i) % (N-1));
                if (g < 0 && tv[kk]) g = kk;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        s_rdy = bus.req_ready_o; s_stall = bus.stall_o; s_we = bus.RegWrite_o;
        s_addr = bus.RDaddr_o;   s_data = bus.RDdata_o;
        chk("ready", 32'(s_rdy), 32'(exp_rdy));
        chk("stall", 32'(s_stall), 32'(tv[0] && g != 0 && !r));
        if (m_init) begin
            chk("regwrite", 32'(s_we), 32'(m_ow));
            if (m_ow || m_after_rst) begin
                chk("rdaddr", 32'(s_addr), 32'(m_oa));
                chk("rddata", s_data, m_od);
            end
        end
        last_g = g;
        @(posedge clk);
        if (r) begin
            m_ptr = 1; m_ow = 1'b0; m_oa = '0; m_od = '0;
            m_init = 1'b1; m_after_rst = 1'b1;
            for (int kk = 0; kk < N; kk++) m_wt[kk] = 0;
        end else begin
            m_after_rst = 1'b0;
            for (int kk = 1; kk < N; kk++)
                m_wt[kk] = (tv[kk] && g != kk) ? ((m_wt[kk] < 15) ? m_wt[kk] + 1 : 15) : 0;
            if (g >= 0) begin
                m_ow = !(DROP_R0 && ta[g] == 5'd0);
                m_oa = ta[g];
                m_od = td[g];
                if (g >= 1) m_ptr = (g == N-1) ? 1 : g + 1;
            end else begin
                m_ow = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        tv = '0;
        step(1'b1);
        step(1'b1);
    endtask

    initial begin
        for (int kk = 0; kk < N; kk++) m_wt[kk] = 0;

        // 1: requester 0 alone
        do_reset();
        tv = 3'b001; ta[0] = 5'd5; td[0] = 32'hDEADBEEF;
        step(1'b0);
        chk("t1_rdy", 32'(s_rdy), 32'h1);
        chk("t1_stall", 32'(s_stall), 32'h0);
        tv = '0;
        step(1'b0);
        chk("t1_we", 32'(s_we), 32'h1);
        chk("t1_addr", 32'(s_addr), 32'd5);
        chk("t1_data", s_data, 32'hDEADBEEF);

        // 2: round-robin between 1 and 2
        do_reset();
        tv = 3'b110; ta[1] = 5'd7; ta[2] = 5'd9; td[1] = 32'h7; td[2] = 32'h9;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk("t2_rr", 32'(s_rdy), (i % 2 == 0) ? 32'h2 : 32'h4);
            if (i > 0) chk("t2_addr", 32'(s_addr), (i % 2 == 1) ? 32'd7 : 32'd9);
        end

        // 3: starvation override
        do_reset();
        tv = 3'b011; ta[0] = 5'd1; td[0] = 32'h1; ta[1] = 5'd3; td[1] = 32'h11;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk("t3_block", 32'(s_rdy), 32'h1);
        end
        step(1'b0);
        chk("t3_starve", 32'(s_rdy), 32'h2);
        chk("t3_stall", 32'(s_stall), 32'h1);
        tv = 3'b001;
        step(1'b0);
        chk("t3_r0", 32'(s_rdy), 32'h1);
        chk("t3_nostall", 32'(s_stall), 32'h0);
        chk("t3_waddr", 32'(s_addr), 32'd3);
        chk("t3_wdata", s_data, 32'h11);

        // 4: write to r0 dropped, pointer still advances
        do_reset();
        tv = 3'b010; ta[1] = 5'd4; td[1] = 32'h44;
        step(1'b0);
        tv = 3'b100; ta[2] = 5'd0; td[2] = 32'h55;
        step(1'b0);
        chk("t4_rdy2", 32'(s_rdy), 32'h4);
        tv = 3'b110; ta[2] = 5'd8;
        step(1'b0);
        chk("t4_drop", 32'(s_we), 32'h0);
        chk("t4_ptr", 32'(s_rdy), 32'h2);

        // 5: reset on a grant cycle
        do_reset();
        tv = 3'b001; ta[0] = 5'd12; td[0] = 32'hCAFE;
        step(1'b0);
        tv = 3'b010; ta[1] = 5'd13;
        step(1'b1);
        chk("t5_rdy", 32'(s_rdy), 32'h0);
        tv = '0;
        step(1'b0);
        chk("t5_we", 32'(s_we), 32'h0);
        chk("t5_addr", 32'(s_addr), 32'h0);
        chk("t5_data", s_data, 32'h0);

        // 6: withdrawal restarts the wait count
        do_reset();
        tv = 3'b011; ta[0] = 5'd2; ta[1] = 5'd6; td[1] = 32'h66;
        for (int i = 0; i < 3; i++) step(1'b0);
        tv = 3'b001;
        step(1'b0);
        tv = 3'b011;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk("t6_block", 32'(s_rdy), 32'h1);
        end
        step(1'b0);
        chk("t6_starve", 32'(s_rdy), 32'h2);

        // random traffic
        do_reset();
        tv = '0;
        for (int c = 0; c < 500; c++) begin
            logic r;
            if (last_g >= 0) tv[last_g] = 1'b0;
            for (int kk = 0; kk < N; kk++) begin
                if (tv[kk]) begin
                    if ($urandom_range(0, 9) == 0) tv[kk] = 1'b0;
                end else if ($urandom_range(0, (kk == 0) ? 1 : 2) == 0) begin
                    tv[kk] = 1'b1;
                    ta[kk] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                    td[kk] = $urandom;
                end
            end
            r = ($urandom_range(0, 99) == 0);
            step(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite/RDaddr/RDdata) among several writeback sources.
- Sources: requester 0 is the pipeline's WB stage; requesters 1..NUM_REQ-1 are multi-cycle units (load miss, mul/div).
- Grants one write per cycle using fixed priority for the pipeline, round-robin among the other requesters, and an anti-starvation override.
- Drives the register file write port from a registered output stage and produces the pipeline stall.

Parameters:
- NUM_REQ, 3: number of requesters, minimum 2; index 0 is the pipeline WB stage.
- MAX_WAIT, 4: consecutive blocked cycles after which a requester 1..NUM_REQ-1 is granted ahead of requester 0. Range 1..15.
- DROP_R0, 1: when 1, accepted requests with address 0 produce no register file write.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_addr_i  in  5*NUM_REQ  destination register; requester k occupies bits [5k+4:5k].
- req_data_i  in  32*NUM_REQ  write data; requester k occupies bits [32k+31:32k].
- req_ready_o  out  NUM_REQ  grant, combinational, one-hot or zero.
- stall_o  out  1  high when req_valid_i[0]=1 and req_ready_o[0]=0.
- RegWrite_o  out  1  write enable to the register file.
- RDaddr_o  out  5  write address to the register file.
- RDdata_o  out  32  write data to the register file.

Behaviour:
- Reset, asserted on any edge where rst_i=1:
  - RegWrite_o=0, RDaddr_o=0, RDdata_o=0.
  - Round-robin pointer = 1; all wait counters = 0.
  - While rst_i=1, req_ready_o=0 and stall_o=0.
  - A reset arriving mid-stream discards any in-flight grant; no write is issued in the following cycle.
- Handshake:
  - A transfer occurs in a cycle where req_valid_i[k]=1 and req_ready_o[k]=1.
  - A requester holds valid, addr and data stable until it is granted.
  - Dropping valid before a grant withdraws the request; this is legal.
- Grant selection, evaluated combinationally each cycle, at most one grant:
  1. Starvation: if any k in 1..NUM_REQ-1 has valid=1 and wait_cnt[k] >= MAX_WAIT, grant the one found first scanning from the round-robin pointer.
  2. Else if req_valid_i[0]=1, grant requester 0.
  3. Else grant the first valid k in 1..NUM_REQ-1, scanning upward from the pointer with wrap from NUM_REQ-1 to 1.
  4. Else no grant.
- Round-robin pointer:
  - After a grant to k >= 1, the pointer becomes k+1, wrapping to 1 after NUM_REQ-1.
  - It is unchanged after a grant to requester 0 and on idle cycles.
- Wait counters, k >= 1, 4-bit saturating:
  - Increment when valid=1 and not granted.
  - Clear to 0 on grant or when valid=0.
- Output stage, 1-cycle latency:
  - On the edge after a transfer from k: RegWrite_o=1, RDaddr_o=addr_k, RDdata_o=data_k.
  - If DROP_R0=1 and addr_k=0, RegWrite_o=0 but the request is still accepted.
  - With no transfer: RegWrite_o=0; RDaddr_o and RDdata_o hold their last values.
- Throughput: one write per cycle sustained, no bubbles between back-to-back grants.
- Downstream timing: the register file forwards write data combinationally in the write cycle, so a read of RDaddr_o in that cycle returns RDdata_o. No extra bypass is required here.
- Requester 0 behaviour: stall_o is asserted only in cycles where starvation rule 1 preempts it. Requester 0 is never blocked more than one cycle in a row while only one starving requester is present.

Test Plan:
1. Reset, then requester 0 alone: valid0=1, addr=5, data=0xDEADBEEF → ready0=1 the same cycle; next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF; stall_o=0 throughout.
2. Requesters 1 and 2 held valid (addr 7 and 9), requester 0 idle → grants alternate 1,2,1,... starting with 1 after reset; output addresses 7,9 on consecutive cycles.
3. Requester 0 valid every cycle plus requester 1 valid (addr 3, data 0x11), MAX_WAIT=4 → requester 1 blocked cycles 0-3, granted at cycle 4 with stall_o=1 that cycle only; write of r3=0x11 one cycle later; requester 0 granted again at cycle 5.
4. DROP_R0=1, requester 2 requests addr 0 with data 0x55 → ready2=1; next cycle RegWrite_o=0; the pointer still advances to 1.
5. rst_i asserted in the same cycle that requester 1 would be granted → ready1=0, no write next cycle, all outputs 0.
6. Requester 1 drops valid after 3 blocked cycles, then reasserts → wait counter restarts from 0; no starvation grant until 4 further blocked cycles.
